// File: rtl/micro_seq_pkg.sv
// Shared encodings for the micro-sequencer: next-address selects, FSM states, flag bit positions.
package micro_seq_pkg;

   localparam logic [1:0] SEL_DISPATCH    = 2'd0;
   localparam logic [1:0] SEL_SEQUENTIAL  = 2'd1;
   localparam logic [1:0] SEL_CONDITIONAL = 2'd2;
   localparam logic [1:0] SEL_DIRECT      = 2'd3;

   localparam int FLAG_Z = 0;
   localparam int FLAG_N = 1;
   localparam int FLAG_C = 2;
   localparam int FLAG_V = 3;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DISP_WAIT,
      ST_HALT
   } seqState_t;

endpackage

// File: rtl/micro_ret_stack.sv
// LIFO of micro-return addresses; push into a full stack or pop from an empty one is ignored here,
// the caller decides how to react.
module micro_ret_stack #(
   parameter int DEPTH = 4,
   parameter int AW    = 6
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic          pop,
   input  logic [AW-1:0] pushData,
   output logic [AW-1:0] top,
   output logic          full,
   output logic          empty
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [AW-1:0] mem [DEPTH];
   logic [CW-1:0] count;

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);
   assign top   = mem[IW'(count - CW'(1))];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= '0;
      end else if (push && !full) begin
         mem[IW'(count)] <= pushData;
         count           <= count + CW'(1);
      end else if (pop && !empty) begin
         count <= count - CW'(1);
      end
   end

endmodule

// File: rtl/micro_sequencer.sv
// Micro-program counter sequencer: dispatch handshake, memory stall, halt/resume.
// Optional return stack for microsubroutines when MICRO_CALL_STACK_EN is defined.
//
// state        | meaning
// ST_IDLE      | one bubble cycle after reset/resume, upc = RESET_ADDR
// ST_RUN       | control word at upc is live, upc advances per next_sel
// ST_DISP_WAIT | waiting for op_valid to take the dispatch target
// ST_HALT      | frozen until resume
module micro_sequencer
   import micro_seq_pkg::*;
#(
   parameter int            AW            = 6,
   parameter logic [AW-1:0] RESET_ADDR    = '0,
   parameter logic [AW-1:0] BR_TRUE_ADDR  = AW'(12),
   parameter logic [AW-1:0] BR_FALSE_ADDR = AW'(13),
   parameter int            STACK_DEPTH   = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [1:0]    ctrl_next_sel,
   input  logic [AW-1:0] ctrl_next_addr,
   input  logic [1:0]    ctrl_cond_sel,
   input  logic          ctrl_wait_mem,
   input  logic          ctrl_halt,
   input  logic          ctrl_call,
   input  logic          ctrl_ret,
   input  logic [3:0]    cond_flags,
   input  logic          mem_busy,
   input  logic          op_valid,
   input  logic [AW-1:0] op_dispatch,
   input  logic          resume,
   output logic          op_ready,
   output logic [AW-1:0] upc,
   output logic          upc_valid,
   output logic          stall,
   output logic          halted,
   output logic          stack_err
);

   seqState_t     state;
   logic [AW-1:0] upcNext;
   logic          dispMiss;
   logic          memHold;

`ifdef MICRO_CALL_STACK_EN
   logic          stackPush, stackPop, stackFull, stackEmpty, stackErrSet, stackErr;
   logic [AW-1:0] stackTop;
`endif

   assign memHold = ctrl_wait_mem & mem_busy;

   always_comb begin
      upcNext  = upc;
      op_ready = 1'b0;
      stall    = 1'b0;
      dispMiss = 1'b0;
`ifdef MICRO_CALL_STACK_EN
      stackPush   = 1'b0;
      stackPop    = 1'b0;
      stackErrSet = 1'b0;
`endif
      case (state)
         ST_RUN: begin
            if (!ctrl_halt) begin
               if (memHold) begin
                  stall = 1'b1;
               end
`ifdef MICRO_CALL_STACK_EN
               else if (ctrl_ret) begin
                  stackPop    = !stackEmpty;
                  stackErrSet = stackEmpty;
                  upcNext     = stackEmpty ? RESET_ADDR : stackTop;
               end else if (ctrl_call) begin
                  // full stack still takes the jump; only the return address is lost
                  stackPush   = !stackFull;
                  stackErrSet = stackFull;
                  upcNext     = ctrl_next_addr;
               end
`endif
               else begin
                  case (ctrl_next_sel)
                     SEL_DISPATCH: begin
                        if (op_valid) begin
                           upcNext  = op_dispatch;
                           op_ready = 1'b1;
                        end else begin
                           stall    = 1'b1;
                           dispMiss = 1'b1;
                        end
                     end
                     SEL_SEQUENTIAL:  upcNext = upc + AW'(1);
                     SEL_CONDITIONAL: upcNext = cond_flags[ctrl_cond_sel] ? BR_TRUE_ADDR : BR_FALSE_ADDR;
                     default:         upcNext = ctrl_next_addr;
                  endcase
               end
            end
         end
         ST_DISP_WAIT: begin
            if (op_valid) begin
               upcNext  = op_dispatch;
               op_ready = 1'b1;
            end else begin
               stall = 1'b1;
            end
         end
         ST_HALT: begin
            if (resume) upcNext = RESET_ADDR;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         upc   <= RESET_ADDR;
      end else begin
         upc <= upcNext;
         case (state)
            ST_IDLE:      state <= ST_RUN;
            ST_RUN: begin
               if (ctrl_halt)     state <= ST_HALT;
               else if (dispMiss) state <= ST_DISP_WAIT;
            end
            ST_DISP_WAIT: if (op_valid) state <= ST_RUN;
            ST_HALT:      if (resume)   state <= ST_IDLE;
            default:      state <= ST_IDLE;
         endcase
      end
   end

   assign upc_valid = (state == ST_RUN);
   assign halted    = (state == ST_HALT);

`ifdef MICRO_CALL_STACK_EN
   micro_ret_stack #(
      .DEPTH(STACK_DEPTH),
      .AW   (AW)
   ) uRetStack (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (stackPush),
      .pop     (stackPop),
      .pushData(upc + AW'(1)),
      .top     (stackTop),
      .full    (stackFull),
      .empty   (stackEmpty)
   );

   always_ff @(posedge clk) begin
      if (!rst_n)           stackErr <= 1'b0;
      else if (stackErrSet) stackErr <= 1'b1;
   end

   assign stack_err = stackErr;
`else
   logic unusedStackIns;
   assign unusedStackIns = ctrl_call ^ ctrl_ret ^ (STACK_DEPTH != 0);
   assign stack_err      = 1'b0;
`endif

endmodule

// File: tb/tb_micro_sequencer.sv
// Scoreboard bench for micro_sequencer: directed scenarios then random stimulus against a
// behavioural model; honours MICRO_CALL_STACK_EN for the return-stack model.
module tb_micro_sequencer;

   localparam int DEPTH  = 4;
   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_DISP = 2;
   localparam int M_HALT = 3;

   typedef struct {
      bit       rstN;
      bit [1:0] sel;
      bit [5:0] addr;
      bit [1:0] cond;
      bit       waitMem, halt, call, ret;
      bit [3:0] flags;
      bit       busy, opValid;
      bit [5:0] disp;
      bit       resume;
   } insT;

   typedef struct {
      int upc;
      bit upcValid, stall, halted, opReady, stackErr;
   } outsT;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] ctrl_next_sel = '0;
   logic [5:0] ctrl_next_addr = '0;
   logic [1:0] ctrl_cond_sel = '0;
   logic       ctrl_wait_mem = 1'b0, ctrl_halt = 1'b0, ctrl_call = 1'b0, ctrl_ret = 1'b0;
   logic [3:0] cond_flags = '0;
   logic       mem_busy = 1'b0, op_valid = 1'b0, resume = 1'b0;
   logic [5:0] op_dispatch = '0;
   logic       op_ready, upc_valid, stall, halted, stack_err;
   logic [5:0] upc;

   micro_sequencer dut (
      .clk(clk), .rst_n(rst_n),
      .ctrl_next_sel(ctrl_next_sel), .ctrl_next_addr(ctrl_next_addr),
      .ctrl_cond_sel(ctrl_cond_sel), .ctrl_wait_mem(ctrl_wait_mem),
      .ctrl_halt(ctrl_halt), .ctrl_call(ctrl_call), .ctrl_ret(ctrl_ret),
      .cond_flags(cond_flags), .mem_busy(mem_busy), .op_valid(op_valid),
      .op_dispatch(op_dispatch), .resume(resume), .op_ready(op_ready),
      .upc(upc), .upc_valid(upc_valid), .stall(stall), .halted(halted),
      .stack_err(stack_err)
   );

   always #5 clk = ~clk;

   int   checks = 0;
   int   errors = 0;
   outsT expQ[$];

   int mMode = M_IDLE;
   int mUpc  = 0;
   bit mErr  = 1'b0;
   int mStack[$];

   function automatic void check(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic insT nop();
      insT s;
      s = '{default: 0};
      s.rstN = 1'b1;
      s.sel  = 2'd1;
      return s;
   endfunction

   task automatic modelReset();
      mMode = M_IDLE;
      mUpc  = 0;
      mErr  = 1'b0;
      mStack.delete();
   endtask

   // Expected outputs for this cycle from the current model state, then advance the model.
   task automatic modelStep(input insT s, output outsT e);
      e.upc      = mUpc;
      e.upcValid = (mMode == M_RUN);
      e.halted   = (mMode == M_HALT);
      e.stall    = 1'b0;
      e.opReady  = 1'b0;
      e.stackErr = mErr;
      case (mMode)
         M_IDLE: mMode = M_RUN;
         M_RUN: begin
            if (s.halt) mMode = M_HALT;
            else if (s.waitMem && s.busy) e.stall = 1'b1;
`ifdef MICRO_CALL_STACK_EN
            else if (s.ret) begin
               if (mStack.size() == 0) begin
                  mUpc = 0;
                  mErr = 1'b1;
               end else mUpc = mStack.pop_back();
            end else if (s.call) begin
               if (mStack.size() == DEPTH) mErr = 1'b1;
               else mStack.push_back((mUpc + 1) % 64);
               mUpc = s.addr;
            end
`endif
            else if (s.sel == 2'd0) begin
               if (s.opValid) begin
                  mUpc      = s.disp;
                  e.opReady = 1'b1;
               end else begin
                  e.stall = 1'b1;
                  mMode   = M_DISP;
               end
            end
            else if (s.sel == 2'd1) mUpc = (mUpc + 1) % 64;
            else if (s.sel == 2'd2) mUpc = s.flags[s.cond] ? 12 : 13;
            else mUpc = s.addr;
         end
         M_DISP: begin
            if (s.opValid) begin
               mUpc      = s.disp;
               e.opReady = 1'b1;
               mMode     = M_RUN;
            end else e.stall = 1'b1;
         end
         default: begin
            if (s.resume) begin
               mMode = M_IDLE;
               mUpc  = 0;
            end
         end
      endcase
   endtask

   task automatic cycle(input insT s);
      outsT e;
      @(negedge clk);
      rst_n          = s.rstN;
      ctrl_next_sel  = s.sel;
      ctrl_next_addr = s.addr;
      ctrl_cond_sel  = s.cond;
      ctrl_wait_mem  = s.waitMem;
      ctrl_halt      = s.halt;
      ctrl_call      = s.call;
      ctrl_ret       = s.ret;
      cond_flags     = s.flags;
      mem_busy       = s.busy;
      op_valid       = s.opValid;
      op_dispatch    = s.disp;
      resume         = s.resume;
      if (s.rstN) begin
         modelStep(s, e);
         expQ.push_back(e);
      end else modelReset();
   endtask

   task automatic settle();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every cycle the DUT presents a full output vector; compare it to the queued expectation.
   initial begin
      outsT e;
      forever begin
         @(negedge clk);
         #2;
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            check("upc", int'(upc), e.upc);
            check("upc_valid", int'(upc_valid), int'(e.upcValid));
            check("stall", int'(stall), int'(e.stall));
            check("halted", int'(halted), int'(e.halted));
            check("op_ready", int'(op_ready), int'(e.opReady));
            check("stack_err", int'(stack_err), int'(e.stackErr));
         end
      end
   end

   initial begin
      insT s;
      s = nop();
      s.rstN = 1'b0;
      cycle(s);
      cycle(s);

      // sequential advance and wrap
      s = nop();
      repeat (4) cycle(s);
      settle();
      check("seq_upc3", int'(upc), 3);
      s.sel = 2'd3; s.addr = 6'd63;
      cycle(s);
      s = nop();
      cycle(s);
      settle();
      check("wrap_upc0", int'(upc), 0);

      // dispatch wait then accept
      s = nop(); s.sel = 2'd0;
      repeat (3) cycle(s);
      s.opValid = 1'b1; s.disp = 6'h2A;
      cycle(s);
      settle();
      check("dispatch_upc", int'(upc), 42);

      // conditional branch
      s = nop(); s.sel = 2'd2; s.cond = 2'd0; s.flags = 4'b0001;
      cycle(s);
      settle();
      check("br_taken", int'(upc), 12);
      s.flags = 4'b1110;
      cycle(s);
      settle();
      check("br_not_taken", int'(upc), 13);

      // memory wait, then halt beats wait
      s = nop(); s.waitMem = 1'b1; s.busy = 1'b1;
      repeat (2) cycle(s);
      s.busy = 1'b0;
      cycle(s);
      settle();
      check("mem_advance", int'(upc), 14);
      s.busy = 1'b1; s.halt = 1'b1;
      cycle(s);
      s = nop();
      repeat (2) cycle(s);
      settle();
      check("halt_flag", int'(halted), 1);
      check("halt_upc", int'(upc), 14);
      s.resume = 1'b1;
      cycle(s);
      settle();
      check("resume_upc", int'(upc), 0);
      check("resume_halted", int'(halted), 0);

      // reset while in dispatch wait with an opcode offered
      s = nop();
      cycle(s);
      s.sel = 2'd0;
      cycle(s);
      s.rstN = 1'b0; s.opValid = 1'b1; s.disp = 6'h15;
      cycle(s);
      s = nop();
      cycle(s);
      settle();
      check("rst_disp_upc", int'(upc), 0);
      check("rst_disp_ready", int'(op_ready), 0);

`ifdef MICRO_CALL_STACK_EN
      s = nop();
      cycle(s);
      for (int i = 0; i < 5; i++) begin
         s = nop(); s.call = 1'b1; s.addr = 6'(20 + i);
         cycle(s);
      end
      settle();
      check("call_overflow_err", int'(stack_err), 1);
      s = nop(); s.ret = 1'b1;
      repeat (5) cycle(s);
      settle();
      check("ret_underflow_upc", int'(upc), 0);
`endif

      // random traffic
      for (int n = 0; n < 3000; n++) begin
         s.rstN    = ($urandom_range(0, 99) != 0);
         s.sel     = 2'($urandom_range(0, 3));
         s.addr    = 6'($urandom_range(0, 63));
         s.cond    = 2'($urandom_range(0, 3));
         s.waitMem = ($urandom_range(0, 3) == 0);
         s.busy    = ($urandom_range(0, 1) == 0);
         s.halt    = ($urandom_range(0, 19) == 0);
         s.call    = ($urandom_range(0, 7) == 0);
         s.ret     = ($urandom_range(0, 7) == 0);
         s.flags   = 4'($urandom_range(0, 15));
         s.opValid = ($urandom_range(0, 2) != 0);
         s.disp    = 6'($urandom_range(0, 63));
         s.resume  = ($urandom_range(0, 2) == 0);
         cycle(s);
      end

      s = nop();
      repeat (3) cycle(s);
      repeat (3) @(posedge clk);
      check("queue_drained", expQ.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
